// File: rtl/shift_pipe_monitor.sv
// shift_pipe_monitor: receiving-end checker for a two-stage shift pipeline
// (a -> b -> c). It keeps its own history of a and compares both stage
// outputs against it. It counts compare cycles and mismatch cycles, and it
// can stop on the first error.
// Build option: define PIPE_MON_BLOCKING_EN to check a blocking-style
// pipeline, where b and c both equal a from one edge earlier and the
// warm-up depth is 1. By default it checks a nonblocking pipeline, where
// c lags by two edges and the warm-up depth is 2.
module shift_pipe_monitor #(
  parameter int WIDTH       = 4,
  parameter int CNT_W       = 8,
  parameter int STOP_ON_ERR = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic             err_b,
  output logic             err_c,
  output logic             sticky_err,
  output logic [CNT_W-1:0] chk_cnt,
  output logic [CNT_W-1:0] mis_cnt,
  output logic [1:0]       state
);

`ifdef PIPE_MON_BLOCKING_EN
  localparam int DEPTH = 1;
`else
  localparam int DEPTH = 2;
`endif
  localparam logic [1:0] DEPTH_W = 2'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WARM  = 2'd1,
    CHECK = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       warm_q, warm_d;
  logic [WIDTH-1:0] h1_q;
  logic [WIDTH-1:0] exp_c;
  logic             hist_shift, hist_clr, cmp_en;
  logic             mis_b, mis_c, mis_any;
  logic [CNT_W-1:0] chk_q, chk_d, mis_q, mis_d;
  logic             sticky_q, sticky_d;
  logic             err_b_q, err_c_q;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

`ifdef PIPE_MON_BLOCKING_EN
  assign exp_c = h1_q;
`else
  logic [WIDTH-1:0] h2_q;
  assign exp_c = h2_q;

  // Second history tap: a from two enabled edges earlier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          h2_q <= '0;
    else if (hist_clr)   h2_q <= '0;
    else if (hist_shift) h2_q <= h1_q;
  end
`endif

  // First history tap: a from one enabled edge earlier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          h1_q <= '0;
    else if (hist_clr)   h1_q <= '0;
    else if (hist_shift) h1_q <= a;
  end

  assign mis_b   = (b != h1_q);
  assign mis_c   = (c != exp_c);
  assign mis_any = mis_b | mis_c;

  // Next state: warm-up runs DEPTH enabled edges (the IDLE exit edge counts)
  // before compares start. Dropping en always returns to IDLE.
  always_comb begin
    state_d    = state_q;
    warm_d     = warm_q;
    hist_shift = 1'b0;
    hist_clr   = 1'b0;
    cmp_en     = 1'b0;
    if (!en) begin
      state_d  = IDLE;
      warm_d   = '0;
      hist_clr = 1'b1;
    end else begin
      case (state_q)
        IDLE, WARM: begin
          hist_shift = 1'b1;
          warm_d     = warm_q + 2'd1;
          if (warm_q + 2'd1 >= DEPTH_W) state_d = CHECK;
          else                          state_d = WARM;
        end
        CHECK: begin
          hist_shift = 1'b1;
          cmp_en     = 1'b1;
          // A clear in the same cycle wins over stopping.
          if ((STOP_ON_ERR != 0) && mis_any && !clr) state_d = HALT;
        end
        HALT: begin
          if (clr) begin
            state_d = WARM;
            warm_d  = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Counter and sticky-error update. clr overrides a same-cycle mismatch.
  always_comb begin
    chk_d    = chk_q;
    mis_d    = mis_q;
    sticky_d = sticky_q;
    if (cmp_en) begin
      chk_d = sat_inc(chk_q);
      if (mis_any) begin
        mis_d    = sat_inc(mis_q);
        sticky_d = 1'b1;
      end
    end
    if (clr) begin
      chk_d    = '0;
      mis_d    = '0;
      sticky_d = 1'b0;
    end
  end

  // State, warm-up count, counters and error pulses are all registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      warm_q   <= '0;
      chk_q    <= '0;
      mis_q    <= '0;
      sticky_q <= 1'b0;
      err_b_q  <= 1'b0;
      err_c_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      warm_q   <= warm_d;
      chk_q    <= chk_d;
      mis_q    <= mis_d;
      sticky_q <= sticky_d;
      err_b_q  <= cmp_en & mis_b;
      err_c_q  <= cmp_en & mis_c;
    end
  end

  assign err_b      = err_b_q;
  assign err_c      = err_c_q;
  assign sticky_err = sticky_q;
  assign chk_cnt    = chk_q;
  assign mis_cnt    = mis_q;
  assign state      = state_q;

endmodule

// File: tb/tb_shift_pipe_monitor.sv
// Testbench for shift_pipe_monitor. Three instances share one stimulus:
// a default monitor, a stop-on-error monitor, and a 2-bit-counter monitor.
// Expected behaviour comes from a run-log reference model. The model tracks
// how many samples the current run has taken. It derives the expected b and
// c from that log.
module tb_shift_pipe_monitor;

`ifdef PIPE_MON_BLOCKING_EN
  localparam int DEPTH     = 1;
  localparam bit BLK_BUILD = 1'b1;
`else
  localparam int DEPTH     = 2;
  localparam bit BLK_BUILD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, en, clr;
  logic [3:0] a, b, c;

  logic       n_eb, n_ec, n_st, h_eb, h_ec, h_st, s_eb, s_ec, s_st;
  logic [7:0] n_chk, n_mis, h_chk, h_mis;
  logic [1:0] s_chk, s_mis;
  logic [1:0] n_state, h_state, s_state;

  logic [20:0] obs [3];

  int checks   = 0;
  int failures = 0;

  // Reference model state, one slot per instance.
  int         m_chk [3];
  int         m_mis [3];
  int         m_run [3];
  int         m_state [3];
  bit         m_eb [3];
  bit         m_ec [3];
  bit         m_st [3];
  bit         m_halt [3];
  logic [3:0] m_log [3][1024];
  int         cmax [3]  = '{255, 255, 3};
  bit         stopf [3] = '{1'b0, 1'b1, 1'b0};

  // The bench's own copy of the pipeline under observation.
  logic [3:0] p1, p2;
  logic [3:0] seq [5] = '{4'h3, 4'h7, 4'hF, 4'hA, 4'h2};

  always #5 clk = ~clk;

  shift_pipe_monitor #(.WIDTH(4), .CNT_W(8), .STOP_ON_ERR(0)) u_nb (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .a(a), .b(b), .c(c),
    .err_b(n_eb), .err_c(n_ec), .sticky_err(n_st),
    .chk_cnt(n_chk), .mis_cnt(n_mis), .state(n_state));

  shift_pipe_monitor #(.WIDTH(4), .CNT_W(8), .STOP_ON_ERR(1)) u_halt (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .a(a), .b(b), .c(c),
    .err_b(h_eb), .err_c(h_ec), .sticky_err(h_st),
    .chk_cnt(h_chk), .mis_cnt(h_mis), .state(h_state));

  shift_pipe_monitor #(.WIDTH(4), .CNT_W(2), .STOP_ON_ERR(0)) u_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .a(a), .b(b), .c(c),
    .err_b(s_eb), .err_c(s_ec), .sticky_err(s_st),
    .chk_cnt(s_chk), .mis_cnt(s_mis), .state(s_state));

  assign obs[0] = {n_eb, n_ec, n_st, n_chk, n_mis, n_state};
  assign obs[1] = {h_eb, h_ec, h_st, h_chk, h_mis, h_state};
  assign obs[2] = {s_eb, s_ec, s_st, 6'd0, s_chk, 6'd0, s_mis, s_state};

  function automatic logic [20:0] exp_pack(input int i);
    return {m_eb[i], m_ec[i], m_st[i], 8'(m_chk[i]), 8'(m_mis[i]), 2'(m_state[i])};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_chk[i] = 0; m_mis[i] = 0; m_run[i] = 0; m_state[i] = 0;
      m_eb[i] = 1'b0; m_ec[i] = 1'b0; m_st[i] = 1'b0; m_halt[i] = 1'b0;
    end
  endtask

  // One rising edge, as seen by each monitor, described by its rules.
  task automatic model_edge(input logic e, input logic cl, input logic [3:0] av,
                            input logic [3:0] bv, input logic [3:0] cv);
    for (int i = 0; i < 3; i++) begin
      m_eb[i] = 1'b0;
      m_ec[i] = 1'b0;
      if (!e) begin
        m_halt[i]  = 1'b0;
        m_run[i]   = 0;
        m_state[i] = 0;
        if (cl) begin m_chk[i] = 0; m_mis[i] = 0; m_st[i] = 1'b0; end
      end else if (m_halt[i]) begin
        if (cl) begin
          m_halt[i]  = 1'b0;
          m_run[i]   = 0;
          m_state[i] = 1;
          m_chk[i] = 0; m_mis[i] = 0; m_st[i] = 1'b0;
        end
      end else begin
        if (m_run[i] >= DEPTH) begin
          m_eb[i]  = (bv !== m_log[i][m_run[i]-1]);
          m_ec[i]  = (cv !== m_log[i][m_run[i]-DEPTH]);
          m_chk[i] = (m_chk[i] < cmax[i]) ? m_chk[i] + 1 : m_chk[i];
          if (m_eb[i] || m_ec[i]) begin
            m_mis[i] = (m_mis[i] < cmax[i]) ? m_mis[i] + 1 : m_mis[i];
            m_st[i]  = 1'b1;
            if (stopf[i] && !cl) m_halt[i] = 1'b1;
          end
        end
        if (cl) begin m_chk[i] = 0; m_mis[i] = 0; m_st[i] = 1'b0; end
        if (m_run[i] < 1023) begin
          m_log[i][m_run[i]] = av;
          m_run[i]++;
        end
        m_state[i] = m_halt[i] ? 3 : ((m_run[i] >= DEPTH) ? 2 : 1);
      end
    end
  endtask

  // Drive one cycle from a negedge: b/c come from the bench pipeline
  // (blocking or nonblocking style), optionally overridden by a fault value.
  task automatic step(input logic e, input logic cl, input logic [3:0] av, input bit blk,
                      input bit fb, input bit fc, input logic [3:0] fv);
    logic [3:0] bv, cv;
    bv = p1;
    cv = blk ? p1 : p2;
    if (fb) bv = fv;
    if (fc) cv = fv;
    en = e; clr = cl; a = av; b = bv; c = cv;
    @(posedge clk);
    model_edge(e, cl, av, bv, cv);
    p2 = p1;
    p1 = av;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; a = '0; b = '0; c = '0;
    p1 = '0; p2 = '0;
    model_reset();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs[i] !== 21'd0) begin
        failures++;
        $display("FAIL reset inst%0d got=%h want=%h", i, obs[i], 21'd0);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_clean();
    step(1'b0, 1'b1, 4'h0, BLK_BUILD, 1'b0, 1'b0, 4'h0);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b0, seq[k], BLK_BUILD, 1'b0, 1'b0, 4'h0);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs[i] !== exp_pack(i)) begin
          failures++;
          $display("FAIL clean edge%0d inst%0d got=%h want=%h", k + 1, i, obs[i], exp_pack(i));
        end
      end
      if (k == 0) begin
        checks++;
        if (n_state !== ((DEPTH == 2) ? 2'd1 : 2'd2)) begin
          failures++;
          $display("FAIL clean_state1 got=%0d want=%0d", n_state, (DEPTH == 2) ? 1 : 2);
        end
      end
      if (k == 1) begin
        checks++;
        if (n_state !== 2'd2) begin
          failures++;
          $display("FAIL clean_state2 got=%0d want=2", n_state);
        end
      end
    end
    checks++;
    if (n_chk !== 8'(5 - DEPTH) || n_mis !== 8'd0 || n_st !== 1'b0) begin
      failures++;
      $display("FAIL clean_counts got chk=%0d mis=%0d sticky=%0d want chk=%0d mis=0 sticky=0",
               n_chk, n_mis, n_st, 5 - DEPTH);
    end
  endtask

  task automatic test_fault();
    int fe;
    fe = DEPTH + 2;
    step(1'b0, 1'b1, 4'h0, BLK_BUILD, 1'b0, 1'b0, 4'h0);
    for (int k = 1; k <= 5; k++) begin
      step(1'b1, 1'b0, seq[k-1], BLK_BUILD, 1'b0, (k == fe), 4'hF);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs[i] !== exp_pack(i)) begin
          failures++;
          $display("FAIL fault edge%0d inst%0d got=%h want=%h", k, i, obs[i], exp_pack(i));
        end
      end
      checks++;
      if (n_ec !== (k == fe) || n_eb !== 1'b0) begin
        failures++;
        $display("FAIL fault_pulse edge%0d got err_b=%0d err_c=%0d want err_b=0 err_c=%0d",
                 k, n_eb, n_ec, (k == fe));
      end
    end
    checks++;
    if (n_mis !== 8'd1 || n_st !== 1'b1) begin
      failures++;
      $display("FAIL fault_counts got mis=%0d sticky=%0d want mis=1 sticky=1", n_mis, n_st);
    end
  endtask

  task automatic test_blocking_dut();
    step(1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b0, seq[k], 1'b1, 1'b0, 1'b0, 4'h0);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs[i] !== exp_pack(i)) begin
          failures++;
          $display("FAIL blkdut edge%0d inst%0d got=%h want=%h", k + 1, i, obs[i], exp_pack(i));
        end
      end
    end
    checks++;
    if (n_mis !== ((DEPTH == 2) ? 8'd3 : 8'd0) || n_chk !== 8'(5 - DEPTH)) begin
      failures++;
      $display("FAIL blkdut_counts got chk=%0d mis=%0d want chk=%0d mis=%0d",
               n_chk, n_mis, 5 - DEPTH, (DEPTH == 2) ? 3 : 0);
    end
  endtask

  task automatic test_halt();
    step(1'b0, 1'b1, 4'h0, BLK_BUILD, 1'b0, 1'b0, 4'h0);
    for (int k = 1; k <= 3; k++) begin
      step(1'b1, 1'b0, seq[k-1], BLK_BUILD, (k == 3), 1'b0, 4'h0);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs[i] !== exp_pack(i)) begin
          failures++;
          $display("FAIL halt edge%0d inst%0d got=%h want=%h", k, i, obs[i], exp_pack(i));
        end
      end
    end
    checks++;
    if (h_state !== 2'd3 || h_chk !== 8'(3 - DEPTH) || h_mis !== 8'd1) begin
      failures++;
      $display("FAIL halt_entry got state=%0d chk=%0d mis=%0d want state=3 chk=%0d mis=1",
               h_state, h_chk, h_mis, 3 - DEPTH);
    end
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b0, 4'($urandom), BLK_BUILD, 1'b1, 1'b0, 4'($urandom));
      checks++;
      if (h_state !== 2'd3 || h_chk !== 8'(3 - DEPTH) || h_mis !== 8'd1 || h_eb !== 1'b0 || h_ec !== 1'b0) begin
        failures++;
        $display("FAIL halt_frozen edge%0d got state=%0d chk=%0d mis=%0d eb=%0d ec=%0d",
                 k, h_state, h_chk, h_mis, h_eb, h_ec);
      end
    end
    step(1'b1, 1'b1, 4'h5, BLK_BUILD, 1'b0, 1'b0, 4'h0);
    checks++;
    if (h_state !== 2'd1 || h_chk !== 8'd0 || h_mis !== 8'd0 || h_st !== 1'b0) begin
      failures++;
      $display("FAIL halt_release got state=%0d chk=%0d mis=%0d sticky=%0d want 1 0 0 0",
               h_state, h_chk, h_mis, h_st);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs[i] !== exp_pack(i)) begin
        failures++;
        $display("FAIL halt_release_model inst%0d got=%h want=%h", i, obs[i], exp_pack(i));
      end
    end
  endtask

  task automatic test_saturation();
    step(1'b0, 1'b1, 4'h0, BLK_BUILD, 1'b0, 1'b0, 4'h0);
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 1'b0, 4'($urandom), BLK_BUILD, 1'b0, 1'b0, 4'h0);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs[i] !== exp_pack(i)) begin
          failures++;
          $display("FAIL sat edge%0d inst%0d got=%h want=%h", k + 1, i, obs[i], exp_pack(i));
        end
      end
      if (k >= DEPTH + 4) begin
        checks++;
        if (s_chk !== 2'd3 || s_mis !== 2'd0) begin
          failures++;
          $display("FAIL sat_hold edge%0d got chk=%0d mis=%0d want chk=3 mis=0", k + 1, s_chk, s_mis);
        end
      end
    end
    checks++;
    if (n_chk !== 8'(10 - DEPTH)) begin
      failures++;
      $display("FAIL sat_wide got chk=%0d want=%0d", n_chk, 10 - DEPTH);
    end
  endtask

  task automatic test_reset_mid();
    step(1'b0, 1'b1, 4'h0, BLK_BUILD, 1'b0, 1'b0, 4'h0);
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 4'($urandom), BLK_BUILD, 1'b0, 1'b1, 4'($urandom));
    checks++;
    if (n_state !== 2'd2) begin
      failures++;
      $display("FAIL rstmid_pre got state=%0d want=2", n_state);
    end
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs[i] !== 21'd0) begin
        failures++;
        $display("FAIL rstmid inst%0d got=%h want=%h", i, obs[i], 21'd0);
      end
    end
    model_reset();
    en = 1'b0; clr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    p1 = '0; p2 = '0;
  endtask

  task automatic test_random();
    logic e, cl, fb, fc;
    bit   blk;
    for (int k = 0; k < 400; k++) begin
      e   = ($urandom_range(0, 9) != 0);
      cl  = ($urandom_range(0, 24) == 0);
      blk = BLK_BUILD ^ ($urandom_range(0, 19) == 0);
      fb  = ($urandom_range(0, 11) == 0);
      fc  = ($urandom_range(0, 11) == 0);
      step(e, cl, 4'($urandom), blk, fb, fc, 4'($urandom));
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs[i] !== exp_pack(i)) begin
          failures++;
          $display("FAIL random step%0d inst%0d got=%h want=%h", k, i, obs[i], exp_pack(i));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_fault();
    test_blocking_dut();
    test_halt();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/shift_pipe_monitor.md
# shift_pipe_monitor

- Receiving-end checker for the two-stage shift pipelines (`a -> b -> c` on `clk`).
- Samples the pipeline input `a` and both stage outputs `b`, `c` every rising edge, and keeps its own delayed history of `a`.
- Flags any stage output that differs from the expected delayed input, counts checks and mismatches, and can halt on the first error.
- Sits beside a pipeline instance in benches and on-chip self-test, in place of manual waveform inspection.

## Interface
Parameters:
- `WIDTH`, 4: data width of `a`, `b`, `c`.
- `CNT_W`, 8: width of `chk_cnt` and `mis_cnt`.
- `STOP_ON_ERR`, 0: 1 = enter HALT on the first mismatch.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  checking enable.
- `clr`  in  1  synchronous clear of counters and sticky error; `rst_n` has priority over `clr`.
- `a`  in  WIDTH  pipeline input, as driven to the DUT.
- `b`  in  WIDTH  DUT first-stage output.
- `c`  in  WIDTH  DUT second-stage output.
- `err_b`  out  1  one-cycle pulse on a `b` mismatch.
- `err_c`  out  1  one-cycle pulse on a `c` mismatch.
- `sticky_err`  out  1  set on any mismatch; held until `clr` or reset.
- `chk_cnt`  out  CNT_W  number of compare cycles; saturates at all-ones.
- `mis_cnt`  out  CNT_W  number of mismatch cycles, counted once per cycle even if both stages mismatch; saturates.
- `state`  out  2  IDLE=0, WARM=1, CHECK=2, HALT=3.

## Operation
Reset values (`rst_n` low, asynchronous):
- All outputs 0; `state` = IDLE.
- History registers `h1`, `h2` = 0; warm counter = 0.

History:
- Each edge with `en`=1 (not HALT) samples the pre-edge values of `a`, `b`, `c`.
- It shifts `h2 <= h1` and `h1 <= a`.

Expected values (nonblocking pipeline):
- `b == h1`: `a` from 1 edge earlier.
- `c == h2`: `a` from 2 edges earlier.

State machine:
- IDLE: `en`=0. History and warm counter are cleared; counters are held. `en`=1 moves to WARM.
- WARM: counts enabled edges without comparing. After DEPTH edges, moves to CHECK; DEPTH = 2.
- CHECK: compares every enabled edge, increments `chk_cnt`, and pulses `err_*` on mismatch. A mismatch with `STOP_ON_ERR`=1 moves to HALT.
- HALT: history, counters and compares are frozen; `err_*` stay 0.
- Any state: `en`=0 returns to IDLE on the next edge. Deassertion mid-WARM restarts warm-up on re-enable.

Counters and clear:
- `clr`=1 zeroes `chk_cnt`, `mis_cnt` and `sticky_err` at that edge.
- It also leaves HALT for WARM if `en`=1, or for IDLE if `en`=0.
- A mismatch in the same cycle as `clr`: the clear wins, and the `err_*` pulse still appears.

Arithmetic:
- Comparisons are full WIDTH, bitwise equality.
- Counters are unsigned and saturate; they never wrap.

## Timing
- `err_b`, `err_c`, `sticky_err`, counters and `state` are all registered.
- They reflect the compare made at edge k and are visible after edge k.
- Latency from a DUT output fault to `err_*`: 1 clock.
- First compare: the 3rd enabled edge after leaving IDLE (2nd under `PIPE_MON_BLOCKING_EN`).
- `rst_n` deassertion is synchronised by the user; no internal synchroniser.

## Configuration
- `PIPE_MON_BLOCKING_EN` defined: checks a blocking-style pipeline.
  - Expected values: `b == h1` and `c == h1`, so both stages equal `a` from 1 edge earlier.
  - DEPTH = 1; `h2` is unused.
- Not defined: the nonblocking expectation above, with DEPTH = 2.

## Test plan
- **Nonblocking DUT, clean sequence.** Drive `a` = 3,7,F,A,2 on successive edges with `en`=1.
  - `state` goes IDLE→WARM→CHECK.
  - Compares begin at the 3rd edge; `chk_cnt`=3 after the 5th edge.
  - `mis_cnt`=0 and `sticky_err`=0.
- **Fault injection, nonblocking expected.** Same stimulus, with `c` forced to F instead of 7 at the 4th edge.
  - `err_c` pulses for 1 cycle; `err_b` stays 0.
  - `mis_cnt`=1 and `sticky_err`=1.
- **Blocking DUT, nonblocking expected.** Blocking DUT with macro undefined, 3,7,F,A,2.
  - `err_c` pulses at each compare, since `c` equals `a` from 1 edge earlier, not 2.
  - `mis_cnt`=3.
- **Blocking DUT, blocking expected.** Same DUT with `PIPE_MON_BLOCKING_EN` defined.
  - `mis_cnt`=0; `chk_cnt`=4 after the 5th edge.
- **HALT and release.** `STOP_ON_ERR`=1 with a mismatch at the 3rd edge.
  - `state`=HALT; counters stay frozen over 5 further edges.
  - `clr`=1 with `en`=1 gives `state`=WARM and counters at 0.
- **Reset and saturation.**
  - `rst_n` low mid-CHECK: all outputs 0 immediately, without a clock edge.
  - `CNT_W`=2 with 5 compares: `chk_cnt`=3, held.
